// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq_core slice: opcode map and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOT   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NAND  = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_XNOR  = 4'b0110;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1010;
  localparam logic [3:0] OP_SHL   = 4'b1011;
  localparam logic [3:0] OP_CLEAR = 4'b1111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit add/subtract unit; SUB is A + ~B + 1, so carry means "no borrow".
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = full[WIDTH-1:0];
    carry = full[WIDTH];
    // Overflow: both effective operands share a sign that the result does not.
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready input, accumulator operand and bit-serial shifts.
// Optional build macro ALU_SATURATE_EN: ADD/SUB saturate on signed overflow instead of wrapping.
import alu_pkg::*;

module alu_seq_core #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d, shamt;
  logic             shl_q, shl_d;
  logic [WIDTH-1:0] acc_q, acc_d, opa, as_sum;
  logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic             vld_q, vld_d, ill_q, ill_d, acc_wr;
  logic             as_carry, as_ovf;

  // Returns {bit shifted out, shifted value} for a single-bit logical shift.
  function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v, input logic left);
    return left ? {v[WIDTH-1], v[WIDTH-2:0], 1'b0} : {v[0], 1'b0, v[WIDTH-1:1]};
  endfunction

`ifdef ALU_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_addsub(input logic signed [WIDTH-1:0] raw,
                                                  input logic ovf);
    logic signed [WIDTH-1:0] lim;
    lim = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    return ovf ? lim : raw;
  endfunction
`endif

  assign in_ready = (state_q == ST_IDLE);
  assign opa      = use_acc ? acc_q : a;
  assign shamt    = b[SHW-1:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (opa),
    .b     (b),
    .sub   (opcode == OP_SUB),
    .sum   (as_sum),
    .carry (as_carry),
    .ovf   (as_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shl_d   = shl_q;
    acc_d   = acc_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    ill_d   = ill_q;
    vld_d   = 1'b0;
    acc_wr  = 1'b0;
    if (state_q == ST_SHIFT) begin
      {c_d, acc_d} = shift1(acc_q, shl_q);
      acc_wr = 1'b1;
      cnt_d  = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) begin
        state_d = ST_IDLE;
        vld_d   = 1'b1;
      end
    end else if (in_valid) begin
      vld_d  = 1'b1;
      ill_d  = 1'b0;
      c_d    = 1'b0;
      v_d    = 1'b0;
      acc_wr = 1'b1;
      case (opcode)
        OP_AND:  acc_d = opa & b;
        OP_OR:   acc_d = opa | b;
        OP_NOT:  acc_d = ~opa;
        OP_XOR:  acc_d = opa ^ b;
        OP_NAND: acc_d = ~(opa & b);
        OP_NOR:  acc_d = ~(opa | b);
        OP_XNOR: acc_d = ~(opa ^ b);
        OP_ADD, OP_SUB: begin
`ifdef ALU_SATURATE_EN
          acc_d = sat_addsub(as_sum, as_ovf);
`else
          acc_d = as_sum;
`endif
          c_d = as_carry;
          v_d = as_ovf;
        end
        OP_SHR, OP_SHL: begin
          shl_d = (opcode == OP_SHL);
          if (shamt == '0) begin
            acc_d = opa;
          end else begin
            // First bit moves at acceptance; the remaining N-1 bits run in ST_SHIFT.
            {c_d, acc_d} = shift1(opa, opcode == OP_SHL);
            cnt_d = shamt - SHW'(1);
            if (shamt != SHW'(1)) begin
              state_d = ST_SHIFT;
              vld_d   = 1'b0;
            end
          end
        end
        OP_CLEAR: acc_d = '0;
        default: begin
          acc_d = acc_q;
          c_d   = c_q;
          v_d   = v_q;
          ill_d = 1'b1;
        end
      endcase
    end
    if (acc_wr) begin
      z_d = (acc_d == '0);
      n_d = acc_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      ill_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
      ill_q   <= ill_d;
      vld_q   <= vld_d;
    end
  end

  assign acc       = acc_q;
  assign out_valid = vld_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=16): directed plan steps, then random ops vs. a reference model.
module tb_alu_seq_core;

  localparam int W  = 16;
  localparam int SW = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, use_acc;
  logic         in_ready, out_valid, flag_c, flag_v, flag_z, flag_n, illegal;
  logic [3:0]   opcode;
  logic [W-1:0] a, b, acc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_acc;
  logic         m_c, m_v, m_ill;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b), .use_acc(use_acc), .acc(acc), .out_valid(out_valid),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n), .illegal(illegal)
  );

  task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: computes result, flags and latency straight from the opcode rules.
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat);
    int sx, sy, r, n;
    sx  = $signed(x);
    sy  = $signed(y);
    n   = int'(y[SW-1:0]);
    lat = 1;
    m_ill = 1'b0;
    case (op)
      4'b0000: begin m_acc = x & y;     m_c = 0; m_v = 0; end
      4'b0001: begin m_acc = x | y;     m_c = 0; m_v = 0; end
      4'b0010: begin m_acc = ~x;        m_c = 0; m_v = 0; end
      4'b0011: begin m_acc = x ^ y;     m_c = 0; m_v = 0; end
      4'b0100: begin m_acc = ~(x & y);  m_c = 0; m_v = 0; end
      4'b0101: begin m_acc = ~(x | y);  m_c = 0; m_v = 0; end
      4'b0110: begin m_acc = ~(x ^ y);  m_c = 0; m_v = 0; end
      4'b1000, 4'b1001: begin
        if (op == 4'b1000) begin
          r     = sx + sy;
          m_c   = (int'(x) + int'(y)) >= (1 << W);
          m_acc = x + y;
        end else begin
          r     = sx - sy;
          m_c   = (x >= y);
          m_acc = x - y;
        end
        m_v = (r > 32767) || (r < -32768);
`ifdef ALU_SATURATE_EN
        if (m_v) m_acc = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
      4'b1010: begin
        m_acc = x >> n;
        m_c   = (n == 0) ? 1'b0 : x[n-1];
        m_v   = 0;
        lat   = (n == 0) ? 1 : n;
      end
      4'b1011: begin
        m_acc = x << n;
        m_c   = (n == 0) ? 1'b0 : x[W-n];
        m_v   = 0;
        lat   = (n == 0) ? 1 : n;
      end
      4'b1111: begin m_acc = '0; m_c = 0; m_v = 0; end
      default: m_ill = 1'b1;
    endcase
  endtask

  // Issue one op, hold junk on the inputs while the core is busy, then check the result.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ua);
    int lat, seen;
    bit is_shift;
    is_shift = (op == 4'b1010) || (op == 4'b1011);
    model_op(op, ua ? m_acc : x, y, lat);
    in_valid = 1'b1; opcode = op; a = x; b = y; use_acc = ua;
    @(posedge clk); #1;
    seen = 1;
    while (!out_valid && seen < 40) begin
      chk_b("busy_in_ready", in_ready, 1'b0);
      opcode  = 4'($urandom);
      a       = W'($urandom);
      b       = W'($urandom);
      use_acc = 1'($urandom);
      @(posedge clk); #1;
      seen++;
    end
    in_valid = 1'b0;
    chk_i("latency", seen, lat);
    chk_w("acc", acc, m_acc);
    chk_b("flag_c", flag_c, m_c);
    if (!is_shift) chk_b("flag_v", flag_v, m_v);
    chk_b("flag_z", flag_z, m_acc == '0);
    chk_b("flag_n", flag_n, m_acc[W-1]);
    chk_b("illegal", illegal, m_ill);
    chk_b("done_in_ready", in_ready, 1'b1);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_b("pulse_end", out_valid, 1'b0);
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0; use_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_w("rst_acc", acc, 16'h0000);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_flags", flag_c | flag_v | flag_z | flag_n, 1'b0);
    chk_b("rst_illegal", illegal, 1'b0);
    m_acc = '0; m_c = 0; m_v = 0; m_ill = 0;

    do_op(4'b1000, 16'h0001, 16'h0001, 1'b0);
    chk_w("add_1_1", acc, 16'h0002);
    idle_cycle();
    do_op(4'b1001, 16'h0002, 16'h0001, 1'b0);
    chk_b("sub_noborrow_c", flag_c, 1'b1);
    do_op(4'b1001, 16'h0000, 16'h0001, 1'b0);
    chk_w("sub_0_1", acc, 16'hFFFF);
    do_op(4'b1000, 16'h7FFF, 16'h0001, 1'b0);
`ifdef ALU_SATURATE_EN
    chk_w("add_ovf_sat", acc, 16'h7FFF);
`else
    chk_w("add_ovf_wrap", acc, 16'h8000);
`endif
    chk_b("add_ovf_v", flag_v, 1'b1);
    do_op(4'b1011, 16'h4002, 16'h0002, 1'b0);
    chk_w("shl_4002_2", acc, 16'h0008);
    chk_b("shl_c", flag_c, 1'b1);
    do_op(4'b0001, 16'hAAAA, 16'h0003, 1'b1);
    chk_w("or_use_acc", acc, 16'h000B);
    idle_cycle();

    // Abort a 15-bit right shift with reset at its third SHIFT edge.
    in_valid = 1'b1; opcode = 4'b1010; a = 16'hFFFF; b = 16'd15; use_acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_b("abort_busy", in_ready, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk_b("abort_no_valid", out_valid, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_w("abort_acc", acc, 16'h0000);
    chk_b("abort_out_valid", out_valid, 1'b0);
    chk_b("abort_in_ready", in_ready, 1'b1);
    m_acc = '0; m_c = 0; m_v = 0; m_ill = 0;
    repeat (16) idle_cycle();

    do_op(4'b0001, 16'h000B, 16'h0000, 1'b0);
    do_op(4'b1100, 16'h1234, 16'h5678, 1'b0);
    chk_w("illegal_acc", acc, 16'h000B);
    chk_b("illegal_flag", illegal, 1'b1);
    do_op(4'b1111, 16'h1234, 16'h5678, 1'b0);
    chk_b("clear_z", flag_z, 1'b1);
    chk_b("clear_illegal", illegal, 1'b0);

    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom);
      case ($urandom_range(0, 5))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        2:       ra = 16'hFFFF;
        default: ra = W'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 16'h0001 : W'($urandom);
      do_op(rop, ra, rb, 1'($urandom));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, registered successor to the 16-bit breadboard ALU. Keeps the same 4-bit opcode map, generalised to WIDTH bits.
- Adds a valid/ready input handshake, an accumulator that can be used as operand A, multi-cycle variable-distance shifts and registered status flags.
- Sits between the opcode source (test FSM or a future sequencer) and whatever consumes the result.

Parameters:
WIDTH, 16, datapath width in bits (>=4)
SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0]

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  opcode and operands are valid this cycle
in_ready  output  1  core can accept an operation (high only in IDLE)
opcode  input  4  operation code (see Behaviour)
a  input  WIDTH  operand A (ignored when use_acc=1)
b  input  WIDTH  operand B; for shifts, b[SHW-1:0] is the shift distance
use_acc  input  1  1: operand A = current accumulator
acc  output  WIDTH  accumulator (the result register)
out_valid  output  1  one-cycle pulse: acc and flags hold a new result
flag_c  output  1  carry / no-borrow / last bit shifted out
flag_v  output  1  signed overflow (ADD/SUB only)
flag_z  output  1  acc == 0
flag_n  output  1  acc[WIDTH-1]
illegal  output  1  last completed opcode was undefined

Behaviour:
- Opcodes: AND 0000, OR 0001, NOT 0010 (~A), XOR 0011, NAND 0100, NOR 0101, XNOR 0110, ADD 1000, SUB 1001 (A-B), SHRIGHT 1010 (logical), SHLEFT 1011, CLEAR 1111. All other codes are undefined.
- Reset: acc=0; all flags=0; illegal=0; out_valid=0; state=IDLE; in_ready=1 in the cycle after rst.
- rst wins over every other input. Asserting it mid-shift aborts the shift; no out_valid is produced for the aborted operation.
- FSM states: IDLE, SHIFT.
- Handshake: an operation is accepted at a rising edge where in_valid && in_ready. Operands are sampled only at acceptance.
- Non-shift ops: acc, flags and illegal are updated at the acceptance edge. out_valid is high for exactly the following cycle. The FSM stays in IDLE, so back-to-back acceptance every cycle is allowed.
- Shift ops, N = b[SHW-1:0]:
  - N=0: acc=A and flag_c=0 at the acceptance edge; behaves as a non-shift op.
  - N>=1: the first 1-bit shift happens at the acceptance edge. The FSM enters SHIFT with counter N-1 and performs one bit per edge.
  - After the Nth shift: acc is final, flag_c = last bit shifted out, out_valid pulses, FSM returns to IDLE.
  - in_ready=0 while in SHIFT. Total latency is N edges.
- ADD: flag_c = carry out of the MSB. SUB: flag_c = 1 when A >= B unsigned (no borrow). flag_v is set on two's-complement overflow.
- Logic ops: flag_c=0, flag_v=0.
- CLEAR: acc=0, flag_c=0, flag_v=0, flag_z=1, flag_n=0.
- Undefined opcode: acc, flag_c and flag_v unchanged; illegal=1; out_valid still pulses.
- illegal is cleared by the next defined opcode.
- flag_z and flag_n always reflect the new acc.
- All arithmetic is modulo 2^WIDTH; there are no sign-extension side effects.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined: when a signed ADD/SUB overflows, acc saturates to 0x7F..F (positive overflow) or 0x80..0 (negative overflow). flag_v=1; flag_c is still computed from the raw sum.
- Undefined: ADD/SUB wrap modulo 2^WIDTH.

Decomposition:
- Shared package alu_pkg: opcode constants (OP_AND..OP_CLEAR), FSM state encoding (ST_IDLE, ST_SHIFT).
- Natural sub-module: alu_addsub, a WIDTH-parametrised combinational add/subtract unit producing sum, carry and overflow. It is instantiated once inside alu_seq_core.

Test Plan (WIDTH=16):
- rst, then ADD a=0x0001 b=0x0001 -> acc=0x0002 at acceptance edge, out_valid high 1 cycle; C=0 V=0 Z=0 N=0.
- SUB a=0x0002 b=0x0001 -> 0x0001, C=1. Then SUB a=0x0000 b=0x0001 -> 0xFFFF, C=0, N=1.
- ADD a=0x7FFF b=0x0001 -> 0x8000, V=1, N=1. With ALU_SATURATE_EN -> 0x7FFF, V=1.
- SHLEFT a=0x4002 b=2 -> in_ready=0 for 1 cycle, acc=0x0008 after 2 edges, C=1. Then OR use_acc=1 b=0x0003 -> 0x000B.
- SHRIGHT a=0xFFFF b=15, rst asserted at 3rd SHIFT edge -> acc=0, no out_valid, in_ready=1 next cycle.
- opcode 1100 with acc=0x000B -> acc unchanged, illegal=1, out_valid pulses. Then CLEAR -> acc=0, Z=1, illegal=0.
